// File: rtl/pll_reconfig_if.sv
// Control/status bundle between a PLL reconfiguration controller and its user.
// The slave side is the controller; the master side drives requests and the raw lock.
interface pll_reconfig_if #(
    parameter int MODE_W = 2
);
    logic              pll_lock;
    logic              cfg_req;
    logic [MODE_W-1:0] cfg_idx;
    logic              pll_reset;
    logic [5:0]        idsel;
    logic [5:0]        fbdsel;
    logic [5:0]        odsel;
    logic              out_rst_n;
    logic              cfg_busy;
    logic              cfg_done;
    logic              cfg_err;
    logic [MODE_W-1:0] cur_mode;

    modport master (
        output pll_lock, cfg_req, cfg_idx,
        input  pll_reset, idsel, fbdsel, odsel, out_rst_n,
               cfg_busy, cfg_done, cfg_err, cur_mode
    );

    modport slave (
        input  pll_lock, cfg_req, cfg_idx,
        output pll_reset, idsel, fbdsel, odsel, out_rst_n,
               cfg_busy, cfg_done, cfg_err, cur_mode
    );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// PLL dynamic reconfiguration sequencer: loads select codes, resets the PLL,
// waits for a stable lock with bounded retries and gates the generated-clock reset.
module pll_reconfig_ctrl #(
    parameter int                    N_MODES      = 4,
    parameter int                    MODE_W       = 2,
    parameter logic [N_MODES*18-1:0] MODE_TABLE   = '0,
    parameter int                    DEFAULT_MODE = 0,
    parameter int                    RST_CYCLES   = 16,
    parameter int                    LOCK_STABLE  = 256,
    parameter int                    LOCK_TIMEOUT = 65535,
    parameter int                    MAX_RETRY    = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    pll_reconfig_if.slave  bus
);

    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int STB_W = $clog2(LOCK_STABLE + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(LOCK_STABLE - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TO_W-1:0]   TO_MAX    = {TO_W{1'b1}};
    localparam logic [RTY_W-1:0]  RTY_LIM   = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0]  RTY_MAX   = {RTY_W{1'b1}};
    localparam logic [MODE_W-1:0] DEF_MODE  = MODE_W'(DEFAULT_MODE);
    localparam logic [17:0]       DEF_ENTRY = MODE_TABLE[18*DEFAULT_MODE +: 18];

    typedef enum logic [2:0] {
        ST_APPLY     = 3'd0,
        ST_PRST      = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_ERROR     = 3'd5
    } state_t;

    state_t             state_r, state_s;
    logic [1:0]         sync_r;
    logic               lock_s;
    logic [MODE_W-1:0]  target_r, target_s;
    logic [MODE_W-1:0]  mode_r, mode_s;
    logic [17:0]        sel_r, sel_s;
    logic               req_r, req_s;
    logic [RST_W-1:0]   rst_cnt_r, rst_cnt_s;
    logic [STB_W-1:0]   stb_cnt_r, stb_cnt_s;
    logic [TO_W-1:0]    to_cnt_r, to_cnt_s, to_inc_s;
    logic [RTY_W-1:0]   rty_cnt_r, rty_cnt_s, rty_inc_s;
    logic               pll_reset_r, pll_reset_s;
    logic               out_rst_n_r, out_rst_n_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               err_r, err_s;
    logic               accept_s;
    logic               idx_ok_s;

    // Out-of-range indices return zero; callers only pass validated modes.
    function automatic logic [17:0] table_entry(input logic [MODE_W-1:0] k);
        logic [17:0] e;
        e = 18'd0;
        for (int i = 0; i < N_MODES; i++) begin
            if (32'(k) == 32'(i)) begin
                e = MODE_TABLE[18*i +: 18];
            end
        end
        return e;
    endfunction

    assign lock_s    = sync_r[1];
    assign accept_s  = bus.cfg_req & ~busy_r;
    assign idx_ok_s  = (32'(bus.cfg_idx) < 32'(N_MODES));
    assign to_inc_s  = (to_cnt_r == TO_MAX) ? to_cnt_r : to_cnt_r + TO_W'(1);
    assign rty_inc_s = (rty_cnt_r == RTY_MAX) ? rty_cnt_r : rty_cnt_r + RTY_W'(1);

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], bus.pll_lock};
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_s   = state_r;
        target_s  = target_r;
        mode_s    = mode_r;
        sel_s     = sel_r;
        req_s     = req_r;
        rst_cnt_s = rst_cnt_r;
        stb_cnt_s = stb_cnt_r;
        to_cnt_s  = to_cnt_r;
        rty_cnt_s = rty_cnt_r;
        done_s    = 1'b0;
        err_s     = err_r;

        case (state_r)
            ST_APPLY: begin
                sel_s     = table_entry(target_r);
                mode_s    = target_r;
                rst_cnt_s = '0;
                stb_cnt_s = '0;
                to_cnt_s  = '0;
                rty_cnt_s = '0;
                state_s   = ST_PRST;
            end
            ST_PRST: begin
                if (rst_cnt_r >= RST_LAST) begin
                    rst_cnt_s = '0;
                    stb_cnt_s = '0;
                    to_cnt_s  = '0;
                    state_s   = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_s = rst_cnt_r + RST_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                to_cnt_s = to_inc_s;
                if (lock_s) begin
                    stb_cnt_s = '0;
                    state_s   = ST_STABLE;
                end else if (to_cnt_r >= TO_LAST) begin
                    rty_cnt_s = rty_inc_s;
                    rst_cnt_s = '0;
                    if (rty_inc_s < RTY_LIM) begin
                        state_s = ST_PRST;
                    end else begin
                        state_s = ST_ERROR;
                        err_s   = 1'b1;
                        done_s  = req_r;
                        req_s   = 1'b0;
                    end
                end else begin
                    state_s = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                // Timeout keeps running so lock chatter cannot extend an attempt forever.
                to_cnt_s = to_inc_s;
                if (!lock_s) begin
                    stb_cnt_s = '0;
                    state_s   = ST_WAIT_LOCK;
                end else if (stb_cnt_r >= STB_LAST) begin
                    rty_cnt_s = '0;
                    done_s    = req_r;
                    err_s     = 1'b0;
                    req_s     = 1'b0;
                    state_s   = ST_RUN;
                end else begin
                    stb_cnt_s = stb_cnt_r + STB_W'(1);
                end
            end
            ST_RUN: begin
                err_s = 1'b0;
                if (accept_s) begin
                    if (idx_ok_s) begin
                        target_s = bus.cfg_idx;
                        req_s    = 1'b1;
                        state_s  = ST_APPLY;
                    end else begin
                        done_s = 1'b1;
                        err_s  = 1'b1;
                    end
                end else if (!lock_s) begin
                    to_cnt_s  = '0;
                    stb_cnt_s = '0;
                    state_s   = ST_WAIT_LOCK;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_ERROR: begin
                err_s = 1'b1;
                if (accept_s) begin
                    if (idx_ok_s) begin
                        err_s    = 1'b0;
                        target_s = bus.cfg_idx;
                        req_s    = 1'b1;
                        state_s  = ST_APPLY;
                    end else begin
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = ST_ERROR;
                end
            end
            default: begin
                state_s = ST_APPLY;
            end
        endcase

        pll_reset_s = (state_s == ST_APPLY) || (state_s == ST_PRST) || (state_s == ST_ERROR);
        out_rst_n_s = (state_s == ST_RUN);
        busy_s      = !((state_s == ST_RUN) || (state_s == ST_ERROR));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_APPLY;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_r    <= DEF_MODE;
            mode_r      <= DEF_MODE;
            sel_r       <= DEF_ENTRY;
            req_r       <= 1'b0;
            rst_cnt_r   <= '0;
            stb_cnt_r   <= '0;
            to_cnt_r    <= '0;
            rty_cnt_r   <= '0;
            pll_reset_r <= 1'b1;
            out_rst_n_r <= 1'b0;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            target_r    <= target_s;
            mode_r      <= mode_s;
            sel_r       <= sel_s;
            req_r       <= req_s;
            rst_cnt_r   <= rst_cnt_s;
            stb_cnt_r   <= stb_cnt_s;
            to_cnt_r    <= to_cnt_s;
            rty_cnt_r   <= rty_cnt_s;
            pll_reset_r <= pll_reset_s;
            out_rst_n_r <= out_rst_n_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

    assign bus.pll_reset = pll_reset_r;
    assign bus.idsel     = sel_r[17:12];
    assign bus.fbdsel    = sel_r[11:6];
    assign bus.odsel     = sel_r[5:0];
    assign bus.out_rst_n = out_rst_n_r;
    assign bus.cfg_busy  = busy_r;
    assign bus.cfg_done  = done_r;
    assign bus.cfg_err   = err_r;
    assign bus.cur_mode  = mode_r;

endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 SHALL have parameter N_MODES, default 4: number of selectable PLL modes (1..16).
REQ-002 SHALL have parameter MODE_W, default 2: width of cfg_idx, ceil(log2(N_MODES)) with a minimum of 1.
REQ-003 SHALL have parameter MODE_TABLE, default 0, width N_MODES*18 bits: entry k at bits [18k+17:18k] is {idsel[5:0], fbdsel[5:0], odsel[5:0]}, raw dynamic-select codes.
REQ-004 SHALL have parameter DEFAULT_MODE, default 0: mode applied after reset.
REQ-005 SHALL have parameter RST_CYCLES, default 16: number of cycles pll_reset is held per attempt (>=1).
REQ-006 SHALL have parameter LOCK_STABLE, default 256: consecutive synced-lock cycles required before release (>=1).
REQ-007 SHALL have parameter LOCK_TIMEOUT, default 65535: number of cycles allowed in WAIT_LOCK per attempt.
REQ-008 SHALL have parameter MAX_RETRY, default 3: number of lock attempts before ERROR (>=1).
REQ-009 SHALL have port clk, input, 1 bit: free-running reference clock; the only clock.
REQ-010 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-011 SHALL have port pll_lock, input, 1 bit: raw PLL LOCK, asynchronous to clk.
REQ-012 SHALL have port cfg_req, input, 1 bit: single-cycle reconfiguration request.
REQ-013 SHALL have port cfg_idx, input, MODE_W bits: requested mode, sampled when cfg_req is high.
REQ-014 SHALL have port pll_reset, output, 1 bit: drives PLL RESET, active high.
REQ-015 SHALL have ports idsel, fbdsel and odsel, output, 6 bits each: drive the PLL IDSEL, FBDSEL and ODSEL inputs.
REQ-016 SHALL have port out_rst_n, output, 1 bit: active-low reset for the generated clock domain.
REQ-017 SHALL have port cfg_busy, output, 1 bit: high in every state except RUN and ERROR.
REQ-018 SHALL have port cfg_done, output, 1 bit: one-cycle pulse marking the end of a request.
REQ-019 SHALL have port cfg_err, output, 1 bit: error level.
REQ-020 SHALL have port cur_mode, output, MODE_W bits: mode currently loaded.

Function
REQ-021 SHALL pass pll_lock through a 2-flop synchronizer to produce lock_s; all decisions use lock_s only.
REQ-022 SHALL implement the states APPLY, PRST, WAIT_LOCK, STABLE, RUN and ERROR.
REQ-023 APPLY SHALL last 1 cycle: load idsel, fbdsel, odsel and cur_mode from the target entry, hold pll_reset=1, clear the counters, then go to PRST.
REQ-024 PRST SHALL hold pll_reset=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with pll_reset=0.
REQ-025 WAIT_LOCK SHALL go to STABLE when lock_s=1; after LOCK_TIMEOUT cycles without lock it SHALL increment retry_cnt.
REQ-026 On timeout with retry_cnt<MAX_RETRY the block SHALL return to PRST with the same mode; otherwise it SHALL go to ERROR.
REQ-027 STABLE SHALL count consecutive lock_s=1 cycles and go to RUN when the count reaches LOCK_STABLE.
REQ-028 In STABLE, lock_s=0 SHALL return the block to WAIT_LOCK and zero the stable count; the timeout count continues.
REQ-029 On entry to RUN the block SHALL set out_rst_n=1 and clear retry_cnt.
REQ-030 On entry to RUN caused by a request, the block SHALL pulse cfg_done with cfg_err=0.
REQ-031 In RUN, lock_s=0 SHALL drive out_rst_n=0 on the next cycle and move to WAIT_LOCK with a fresh timeout, without changing the select codes and without pulsing cfg_done.
REQ-032 ERROR SHALL hold pll_reset=1, out_rst_n=0 and cfg_err=1.
REQ-033 On entry to ERROR caused by a request, the block SHALL pulse cfg_done.
REQ-034 cfg_req SHALL be accepted only when cfg_busy=0 and SHALL be ignored while cfg_busy=1.
REQ-035 An accepted cfg_req with cfg_idx<N_MODES SHALL clear cfg_err, drive out_rst_n=0 next cycle and go to APPLY.
REQ-036 An accepted cfg_req with cfg_idx>=N_MODES SHALL be rejected: state and selects unchanged, cfg_done pulse with cfg_err=1 for that cycle only in RUN, and cfg_err stays 1 in ERROR.
REQ-037 out_rst_n SHALL be 0 in every state except RUN.
REQ-038 If lock_s falls in the same cycle cfg_req is accepted, the request SHALL take priority.
REQ-039 All counters SHALL saturate and never wrap; counter widths SHALL be derived from the parameters with $clog2.

Reset
REQ-040 While rst_n=0 the block SHALL hold: state=APPLY, pll_reset=1, out_rst_n=0, cfg_busy=1, cfg_done=0, cfg_err=0.
REQ-041 While rst_n=0 the block SHALL hold: selects = table[DEFAULT_MODE], cur_mode=DEFAULT_MODE, all counters 0, synchronizer 0.
REQ-042 After reset release the block SHALL sequence DEFAULT_MODE automatically with no cfg_done pulse.
REQ-043 An rst_n assertion mid-sequence SHALL return the block to the REQ-040 and REQ-041 values immediately (asynchronously).

Verification (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRY=2, N_MODES=4)
REQ-044 Bench SHALL cover power-up: rst_n released, pll_lock tied 1 -> pll_reset=1 for 5 cycles (APPLY + PRST), out_rst_n=1 within 2 sync + 8 stable cycles (+1), cfg_done never pulses.
REQ-045 Bench SHALL cover a mode switch: cfg_req with cfg_idx=2 in RUN -> out_rst_n=0 next cycle, selects = entry 2, cur_mode=2, cfg_done pulse with cfg_err=0 on RUN re-entry.
REQ-046 Bench SHALL cover timeout: pll_lock held 0 -> two 32-cycle WAIT_LOCK windows separated by a 4-cycle pll_reset, then ERROR with cfg_err=1 and pll_reset=1.
REQ-047 Bench SHALL cover a lock glitch: pll_lock low for 3 cycles in RUN -> out_rst_n low, select codes unchanged, RUN re-entered after 8 stable cycles, no cfg_done.
REQ-048 Bench SHALL cover a bad index: cfg_idx=5 with N_MODES=4 and MODE_W=3 in RUN -> one cfg_done pulse with cfg_err=1, out_rst_n stays 1.
REQ-049 Bench SHALL cover busy and reset cases: cfg_req during PRST is ignored; rst_n pulsed low in STABLE -> all outputs return to reset values immediately.
